// File: rtl/configurable_sequential_multiplicator.sv
// Shift-add sequential multiplier with run-time signed/unsigned selection.
// One product per WIDTH+1 clocks, busy/done handshake and overflow flag.
module configurable_sequential_multiplicator #(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset_in,
    input  logic                 start_in,
    input  logic                 signed_in,
    input  logic [WIDTH-1:0]     multiplicand_in,
    input  logic [WIDTH-1:0]     multiplier_in,
    output logic [2*WIDTH-1:0]   product_out,
    output logic                 overflow_out,
    output logic                 done_out,
    output logic                 busy_out
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_mnd;
    logic [WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]  r_mtr;
    logic              r_neg;
    logic              r_signed;
    logic [CW-1:0]     r_count;

    logic [WIDTH-1:0]   w_mnd_abs;
    logic [WIDTH-1:0]   w_mtr_abs;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mag;
    logic [2*WIDTH-1:0] w_product;
    logic [WIDTH:0]     w_upper_s;
    logic               w_overflow;
    logic               w_accept;

    // Magnitudes of -2^(WIDTH-1) wrap to 2^(WIDTH-1), which is still correct unsigned.
    assign w_mnd_abs = (signed_in && multiplicand_in[WIDTH-1]) ? -multiplicand_in : multiplicand_in;
    assign w_mtr_abs = (signed_in && multiplier_in[WIDTH-1])   ? -multiplier_in   : multiplier_in;

    assign w_addend  = r_mtr[0] ? r_mnd : '0;
    assign w_sum     = {1'b0, r_acc} + {1'b0, w_addend};

    assign w_mag     = {r_acc, r_mtr};
    assign w_product = r_neg ? -w_mag : w_mag;

    // Signed result fits WIDTH bits only if the upper half is a pure sign extension.
    assign w_upper_s  = w_product[2*WIDTH-1:WIDTH-1];
    assign w_overflow = r_signed ? !((&w_upper_s) || !(|w_upper_s))
                                 : (|w_product[2*WIDTH-1:WIDTH]);

    assign w_accept = start_in && ((r_state == IDLE) || (r_state == DONE));

    always_ff @(posedge clock or posedge reset_in) begin
        if (reset_in) begin
            r_state      <= IDLE;
            r_mnd        <= '0;
            r_acc        <= '0;
            r_mtr        <= '0;
            r_neg        <= 1'b0;
            r_signed     <= 1'b0;
            r_count      <= '0;
            product_out  <= '0;
            overflow_out <= 1'b0;
            done_out     <= 1'b0;
            busy_out     <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_mnd    <= w_mnd_abs;
                        r_mtr    <= w_mtr_abs;
                        r_acc    <= '0;
                        r_count  <= '0;
                        r_signed <= signed_in;
                        r_neg    <= signed_in && (multiplicand_in[WIDTH-1] ^ multiplier_in[WIDTH-1]);
                        done_out <= 1'b0;
                        busy_out <= 1'b1;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    // Shift {carry, acc, mtr} right; the consumed multiplier bit falls off.
                    r_acc   <= w_sum[WIDTH:1];
                    r_mtr   <= {w_sum[0], r_mtr[WIDTH-1:1]};
                    r_count <= r_count + 1'b1;
                    if (r_count == CW'(WIDTH - 1)) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    product_out  <= w_product;
                    overflow_out <= w_overflow;
                    done_out     <= 1'b1;
                    busy_out     <= 1'b0;
                    r_state      <= DONE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_configurable_sequential_multiplicator.sv
// Scoreboard bench: WIDTH=8 directed cases plus WIDTH=16 randomized run.
module tb_configurable_sequential_multiplicator;

    logic        clock;
    logic        reset_in;

    logic        start8, signed8;
    logic [7:0]  mnd8, mtr8;
    logic [15:0] product8;
    logic        overflow8, done8, busy8;

    logic        start16, signed16;
    logic [15:0] mnd16, mtr16;
    logic [31:0] product16;
    logic        overflow16, done16, busy16;

    logic [32:0] exp_q8[$];
    logic [32:0] exp_q16[$];

    int checks = 0;
    int errors = 0;

    configurable_sequential_multiplicator #(.WIDTH(8)) dut8 (
        .clock          (clock),
        .reset_in       (reset_in),
        .start_in       (start8),
        .signed_in      (signed8),
        .multiplicand_in(mnd8),
        .multiplier_in  (mtr8),
        .product_out    (product8),
        .overflow_out   (overflow8),
        .done_out       (done8),
        .busy_out       (busy8)
    );

    configurable_sequential_multiplicator #(.WIDTH(16)) dut16 (
        .clock          (clock),
        .reset_in       (reset_in),
        .start_in       (start16),
        .signed_in      (signed16),
        .multiplicand_in(mnd16),
        .multiplier_in  (mtr16),
        .product_out    (product16),
        .overflow_out   (overflow16),
        .done_out       (done16),
        .busy_out       (busy16)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Independent arithmetic reference: {overflow, product}.
    function automatic logic [32:0] ref_model(input int w, input logic [15:0] a,
                                              input logic [15:0] b, input logic s);
        longint mask, sa, sb, p, pmask;
        logic   ov;
        mask  = (longint'(1) << w) - 1;
        pmask = (longint'(1) << (2 * w)) - 1;
        sa = longint'(a) & mask;
        sb = longint'(b) & mask;
        if (s) begin
            if (sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
            if (sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
        end
        p = sa * sb;
        if (s) ov = (p < -(longint'(1) << (w - 1))) || (p > (longint'(1) << (w - 1)) - 1);
        else   ov = (p > mask);
        return {ov, 32'(p & pmask)};
    endfunction

    task automatic start8_op(input logic [7:0] a, input logic [7:0] b, input logic s, input bit push);
        @(negedge clock);
        mnd8 = a; mtr8 = b; signed8 = s; start8 = 1'b1;
        if (push) exp_q8.push_back(ref_model(8, {8'h00, a}, {8'h00, b}, s));
        @(negedge clock);
        start8 = 1'b0;
    endtask

    // Waits for done, pops the scoreboard and compares; returns edges waited.
    task automatic wait8(input string tag, output int n);
        logic [32:0] e;
        n = 0;
        while (n < 40) begin
            @(posedge clock); #1;
            n++;
            if (done8) break;
        end
        check({tag, "_done"}, 64'(done8), 64'd1);
        check({tag, "_busy_low"}, 64'(busy8), 64'd0);
        if (exp_q8.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = exp_q8.pop_front();
            check({tag, "_product"}, 64'(product8), 64'(e[15:0]));
            check({tag, "_overflow"}, 64'(overflow8), 64'(e[32]));
        end
        $display("op8 %s: product=%h overflow=%0d edges=%0d", tag, product8, overflow8, n);
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic s, input int idx);
        logic [32:0] e;
        int n;
        @(negedge clock);
        mnd16 = a; mtr16 = b; signed16 = s; start16 = 1'b1;
        exp_q16.push_back(ref_model(16, a, b, s));
        @(negedge clock);
        start16 = 1'b0;
        n = 0;
        while (n < 60 && !done16) begin
            @(posedge clock); #1;
            n++;
        end
        e = exp_q16.pop_front();
        if (!done16) check("r16_timeout", 64'(done16), 64'd1);
        check("r16_product", 64'(product16), 64'(e[31:0]));
        check("r16_overflow", 64'(overflow16), 64'(e[32]));
        $display("op16 #%0d: %h x %h s=%0d -> %h ov=%0d", idx, a, b, s, product16, overflow16);
    endtask

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            4: return 16'h0001;
            default: return 16'($urandom());
        endcase
    endfunction

    initial begin
        int n;
        start8 = 0; signed8 = 0; mnd8 = 0; mtr8 = 0;
        start16 = 0; signed16 = 0; mnd16 = 0; mtr16 = 0;
        reset_in = 1'b1;
        #1;
        check("rst_product", 64'(product8), 64'd0);
        check("rst_overflow", 64'(overflow8), 64'd0);
        check("rst_done", 64'(done8), 64'd0);
        check("rst_busy", 64'(busy8), 64'd0);
        @(negedge clock); @(negedge clock);
        reset_in = 1'b0;

        // 12 x 10 unsigned with latency check
        start8_op(8'd12, 8'd10, 1'b0, 1'b1);
        check("u12x10_busy_start", 64'(busy8), 64'd1);
        check("u12x10_done_start", 64'(done8), 64'd0);
        wait8("u12x10", n);
        check("u12x10_latency", 64'(n), 64'd9);

        start8_op(8'd255, 8'd255, 1'b0, 1'b1); wait8("u255x255", n);
        start8_op(8'd15, 8'd17, 1'b0, 1'b1);   wait8("u15x17", n);
        start8_op(8'hFD, 8'h05, 1'b1, 1'b1);   wait8("s_m3x5", n);
        start8_op(8'h80, 8'h80, 1'b1, 1'b1);   wait8("s_m128xm128", n);
        start8_op(8'h80, 8'h01, 1'b1, 1'b1);   wait8("s_m128x1", n);

        // start while busy is ignored
        start8_op(8'd7, 8'd9, 1'b0, 1'b1);
        repeat (3) @(negedge clock);
        mnd8 = 8'd2; mtr8 = 8'd2; start8 = 1'b1;
        @(negedge clock);
        start8 = 1'b0;
        wait8("ignore_7x9", n);

        // restart from DONE
        start8_op(8'd2, 8'd2, 1'b0, 1'b1);
        check("restart_done_drop", 64'(done8), 64'd0);
        check("restart_busy", 64'(busy8), 64'd1);
        wait8("restart_2x2", n);

        // asynchronous reset mid-RUN aborts the operation
        start8_op(8'd200, 8'd3, 1'b0, 1'b0);
        repeat (5) @(posedge clock);
        #2 reset_in = 1'b1;
        #1;
        check("arst_product", 64'(product8), 64'd0);
        check("arst_done", 64'(done8), 64'd0);
        check("arst_busy", 64'(busy8), 64'd0);
        check("arst_overflow", 64'(overflow8), 64'd0);
        @(negedge clock);
        reset_in = 1'b0;
        repeat (12) @(posedge clock);
        #1 check("arst_no_done", 64'(done8), 64'd0);
        start8_op(8'd3, 8'd3, 1'b0, 1'b1);
        wait8("post_rst_3x3", n);
        check("post_rst_latency", 64'(n), 64'd9);

        // WIDTH=16 randomized against the reference model
        for (int i = 0; i < 1000; i++) begin
            op16(pick16(), pick16(), 1'($urandom_range(0, 1)), i);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
